// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared widths, counter encodings and helpers for the BTB predictor
package branch_predictor_pkg;

  localparam int DATA_BUS_BITS = 32;

  // 2-bit saturating counter: 00/01 predict not taken, 10/11 predict taken
  localparam int                      BTB_CTR_BITS  = 2;
  localparam logic [BTB_CTR_BITS-1:0] BTB_CTR_INIT  = 2'b01;
  localparam logic [BTB_CTR_BITS-1:0] BTB_CTR_ALLOC = 2'b10;

  // Sequential next PC; wraps modulo 2^DATA_BUS_BITS
  function automatic logic [DATA_BUS_BITS-1:0] pc_plus4(input logic [DATA_BUS_BITS-1:0] pc);
    return pc + DATA_BUS_BITS'(4);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, execute resolution and perf counter bundle
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  // fetch side
  logic                     fetchPC_valid_unused;
  logic [DATA_BUS_BITS-1:0] fetchPC;
  logic                     predTaken;
  logic [DATA_BUS_BITS-1:0] predTarget;

  // execute side
  logic                     exValid;
  logic [DATA_BUS_BITS-1:0] exPC;
  logic                     exBranchOp;
  logic                     exJump;
  logic                     exTaken;
  logic [DATA_BUS_BITS-1:0] exPCNext;
  logic                     exPredTaken;
  logic [DATA_BUS_BITS-1:0] exPredTarget;
  logic                     mispredict;
  logic [DATA_BUS_BITS-1:0] redirectPC;

  // performance counters
  logic [31:0]              branchCount;
  logic [31:0]              mispredictCount;

  // pipeline side: drives fetch/execute information, consumes predictions
  modport master (
    output fetchPC, exValid, exPC, exBranchOp, exJump, exTaken, exPCNext,
           exPredTaken, exPredTarget,
    input  predTaken, predTarget, mispredict, redirectPC, branchCount, mispredictCount
  );

  // predictor side
  modport slave (
    input  fetchPC, exValid, exPC, exBranchOp, exJump, exTaken, exPCNext,
           exPredTaken, exPredTarget,
    output predTaken, predTarget, mispredict, redirectPC, branchCount, mispredictCount
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - next-state function of a 2-bit saturating counter
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [BTB_CTR_BITS-1:0] ctr,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    set_max,
  output logic [BTB_CTR_BITS-1:0] next
);

  // force-to-max wins over increment, increment wins over decrement
  always_comb begin
    next = ctr;
    if (set_max) begin
      next = '1;
    end else if (inc) begin
      if (ctr != '1) next = ctr + BTB_CTR_BITS'(1);
    end else if (dec) begin
      if (ctr != '0) next = ctr - BTB_CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, mispredict detect and perf counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bus
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_LSB  = 2 + IDX_BITS;

  typedef logic [DATA_BUS_BITS-1:0] word_t;

  logic [ENTRIES-1:0]      valid_q;
  logic [TAG_BITS-1:0]     tag_q    [ENTRIES];
  word_t                   target_q [ENTRIES];
  logic [BTB_CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [31:0]             branch_cnt_q;
  logic [31:0]             mispredict_cnt_q;

  logic [IDX_BITS-1:0]     fetch_idx;
  logic [TAG_BITS-1:0]     fetch_tag;
  logic                    fetch_hit;
  logic                    pred_taken;
  word_t                   seq_pc;

  logic [IDX_BITS-1:0]     ex_idx;
  logic [TAG_BITS-1:0]     ex_tag;
  logic                    ex_hit;
  logic                    ex_update;
  logic                    mispredict;
  logic [BTB_CTR_BITS-1:0] ctr_next;

  // Byte offset and bits above the partial tag take no part in indexing or tagging
  logic unused_ex_pc_bits;
  assign unused_ex_pc_bits = ^{bus.exPC[1:0], bus.exPC[DATA_BUS_BITS-1:TAG_LSB+TAG_BITS]};

  assign fetch_idx = bus.fetchPC[2 +: IDX_BITS];
  assign fetch_tag = bus.fetchPC[TAG_LSB +: TAG_BITS];
  assign ex_idx    = bus.exPC[2 +: IDX_BITS];
  assign ex_tag    = bus.exPC[TAG_LSB +: TAG_BITS];
  assign ex_update = bus.exValid & bus.exBranchOp;

  // Fetch lookup: predict taken only on a tag hit with the counter's upper bit set
  always_comb begin
    seq_pc     = pc_plus4(bus.fetchPC);
    fetch_hit  = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    pred_taken = !reset && fetch_hit && ctr_q[fetch_idx][1];
  end

  assign bus.predTaken  = pred_taken;
  assign bus.predTarget = pred_taken ? target_q[fetch_idx] : seq_pc;

  // Execute-side hit check and misprediction decision against the carried prediction
  always_comb begin
    ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    mispredict = 1'b0;
    if (bus.exValid) begin
      if (bus.exBranchOp) begin
        mispredict = (bus.exTaken != bus.exPredTaken) ||
                     (bus.exTaken && (bus.exPCNext != bus.exPredTarget));
      end else begin
        mispredict = bus.exPredTaken;
      end
    end
  end

  assign bus.mispredict      = mispredict;
  assign bus.redirectPC      = bus.exPCNext;
  assign bus.branchCount     = branch_cnt_q;
  assign bus.mispredictCount = mispredict_cnt_q;

  sat_counter2 u_ctr (
    .ctr     (ctr_q[ex_idx]),
    .inc     (bus.exTaken),
    .dec     (!bus.exTaken),
    .set_max (bus.exJump),
    .next    (ctr_next)
  );

  // Table training: jumps always (re)install at max confidence, hits move the counter,
  // taken misses allocate at weakly-taken, not-taken misses leave the table alone
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= BTB_CTR_INIT;
      end
    end else if (ex_update) begin
      if (bus.exJump || ex_hit) begin
        ctr_q[ex_idx] <= ctr_next;
      end else if (bus.exTaken) begin
        ctr_q[ex_idx] <= BTB_CTR_ALLOC;
      end
      if (bus.exJump || bus.exTaken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= bus.exPCNext;
      end
    end
  end

  // Free-running wrap-around perf counters
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (ex_update)  branch_cnt_q     <= branch_cnt_q + 32'd1;
      if (mispredict) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

endmodule
